// File: rtl/cache_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lc3b_types (package)
//  Purpose  : Shared LC-3b types used by the memory-side cache arbiter:
//             line type, arbiter grant encoding and the line offset width.
//  Revision : 1.0 - initial release
// ============================================================================
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } lc3b_arb_grant;

    // A 16-byte line: the low address bits select a byte inside the line.
    localparam int LC3B_LINE_OFFSET_BITS = 4;

    // The port that wins a tie is always the one that did not win last time.
    function automatic lc3b_arb_grant other_grant(input lc3b_arb_grant g);
        return (g == GRANT_I) ? GRANT_D : GRANT_I;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : cache_arbiter_if
//  Purpose  : Bundles the I-cache, D-cache and physical-memory handshakes
//             seen by the cache arbiter.
//  Modports : slave  - arbiter view (caches and memory drive its inputs)
//             master - environment view (caches + memory model)
//  Revision : 1.0 - initial release
// ============================================================================
interface cache_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    // I-cache side
    logic                  icache_pmem_read;
    logic [ADDR_WIDTH-1:0] icache_pmem_address;
    logic [LINE_WIDTH-1:0] icache_pmem_rdata;
    logic                  icache_pmem_resp;
    // D-cache side
    logic                  dcache_pmem_read;
    logic                  dcache_pmem_write;
    logic [ADDR_WIDTH-1:0] dcache_pmem_address;
    logic [LINE_WIDTH-1:0] dcache_pmem_wdata;
    logic [LINE_WIDTH-1:0] dcache_pmem_rdata;
    logic                  dcache_pmem_resp;
    // Physical memory side
    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  icache_pmem_read, icache_pmem_address,
        output icache_pmem_rdata, icache_pmem_resp,
        input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        output dcache_pmem_rdata, dcache_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output icache_pmem_read, icache_pmem_address,
        input  icache_pmem_rdata, icache_pmem_resp,
        output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        input  dcache_pmem_rdata, dcache_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface
`default_nettype wire

// File: rtl/cache_arbiter_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up-counter that sticks at all-ones instead of wrapping.
//  Ports    : clk, rst (sync, active-high), clear (sync), inc, count
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clear,
    input  wire logic             inc,
    output logic      [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cache_arbiter
//  Purpose  : Shares one physical-memory port between the I-cache and the
//             D-cache, one line transaction at a time, round-robin on ties.
//  Ports    : clk, rst (sync, active-high)
//             bus               - cache/memory handshakes (slave modport)
//             contention_count  - IDLE cycles with both caches requesting
//             transaction_count - completed memory transactions
//  Revision : 1.0 - initial release
// ============================================================================
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    cache_arbiter_if.slave            bus,
    output logic      [CNT_WIDTH-1:0] contention_count,
    output logic      [CNT_WIDTH-1:0] transaction_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SERVE_I = 2'd1;
    localparam logic [1:0] ST_SERVE_D = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    lc3b_arb_grant         r_last_grant;
    lc3b_arb_grant         w_new_grant;
    logic                  w_grant_load;
    logic                  w_ireq;
    logic                  w_dreq;
    logic                  w_contention_inc;
    logic                  w_transaction_inc;
    logic [ADDR_WIDTH-1:0] w_i_line_addr;
    logic [ADDR_WIDTH-1:0] w_d_line_addr;

    assign w_ireq = bus.icache_pmem_read;
    assign w_dreq = bus.dcache_pmem_read | bus.dcache_pmem_write;

    // Memory is line-addressed: the byte offset inside the line is dropped.
    assign w_i_line_addr = {bus.icache_pmem_address[ADDR_WIDTH-1:LC3B_LINE_OFFSET_BITS],
                            {LC3B_LINE_OFFSET_BITS{1'b0}}};
    assign w_d_line_addr = {bus.dcache_pmem_address[ADDR_WIDTH-1:LC3B_LINE_OFFSET_BITS],
                            {LC3B_LINE_OFFSET_BITS{1'b0}}};

    // Read data is broadcast; only the resp strobes identify the owner.
    assign bus.icache_pmem_rdata = bus.pmem_rdata;
    assign bus.dcache_pmem_rdata = bus.pmem_rdata;

    // ------------------------------------------------------------------
    // Next-state and grant selection
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next      = r_state;
        w_new_grant       = r_last_grant;
        w_grant_load      = 1'b0;
        w_contention_inc  = 1'b0;
        w_transaction_inc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ireq && w_dreq) begin
                    w_contention_inc = 1'b1;
                    w_grant_load     = 1'b1;
                    w_new_grant      = other_grant(r_last_grant);
                    w_state_next     = (w_new_grant == GRANT_I) ? ST_SERVE_I : ST_SERVE_D;
                end else if (w_ireq) begin
                    w_grant_load = 1'b1;
                    w_new_grant  = GRANT_I;
                    w_state_next = ST_SERVE_I;
                end else if (w_dreq) begin
                    w_grant_load = 1'b1;
                    w_new_grant  = GRANT_D;
                    w_state_next = ST_SERVE_D;
                end
            end
            ST_SERVE_I: begin
                // A dropped request is an abort: leave without counting.
                if (!w_ireq) begin
                    w_state_next = ST_IDLE;
                end else if (bus.pmem_resp) begin
                    w_state_next      = ST_IDLE;
                    w_transaction_inc = 1'b1;
                end
            end
            ST_SERVE_D: begin
                if (!w_dreq) begin
                    w_state_next = ST_IDLE;
                end else if (bus.pmem_resp) begin
                    w_state_next      = ST_IDLE;
                    w_transaction_inc = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GRANT_D;
        end else begin
            r_state <= w_state_next;
            if (w_grant_load) begin
                r_last_grant <= w_new_grant;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory strobes and cache responses. Everything is gated by the
    // live request so an abort drops the strobes in the same cycle, and
    // by rst so a reset mid-transaction silences the bus immediately.
    // ------------------------------------------------------------------
    always_comb begin
        bus.pmem_read        = 1'b0;
        bus.pmem_write       = 1'b0;
        bus.pmem_address     = '0;
        bus.pmem_wdata       = '0;
        bus.icache_pmem_resp = 1'b0;
        bus.dcache_pmem_resp = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_SERVE_I: begin
                    bus.pmem_read        = w_ireq;
                    bus.pmem_address     = w_i_line_addr;
                    bus.icache_pmem_resp = w_ireq & bus.pmem_resp;
                end
                ST_SERVE_D: begin
                    // Write wins if the D-cache raises both strobes.
                    bus.pmem_write       = bus.dcache_pmem_write;
                    bus.pmem_read        = bus.dcache_pmem_read & ~bus.dcache_pmem_write;
                    bus.pmem_address     = w_d_line_addr;
                    bus.pmem_wdata       = bus.dcache_pmem_wdata;
                    bus.dcache_pmem_resp = w_dreq & bus.pmem_resp;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    sat_counter #(.WIDTH(CNT_WIDTH)) u_contention_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (w_contention_inc),
        .count (contention_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_transaction_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (w_transaction_inc),
        .count (transaction_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_arbiter
//  Purpose  : Self-checking bench for cache_arbiter: directed scenarios
//             followed by random traffic, compared against a transaction-
//             level ownership model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter;
    import lc3b_types::*;

    localparam int AW   = 16;
    localparam int LW   = 128;
    // Narrow counters keep the saturation scenario short.
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] contention_count;
    logic [CW-1:0] transaction_count;

    always #5 clk = ~clk;

    cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .contention_count  (contention_count),
        .transaction_count (transaction_count)
    );

    // Model: who owns memory (0 none, 1 I-cache, 2 D-cache), who won last.
    int checks = 0;
    int errors = 0;
    int m_owner = 0;
    int m_last  = 2;
    int m_cont  = 0;
    int m_trans = 0;
    int i_pulses = 0;
    int d_pulses = 0;
    int grants[$];

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge, advance model at posedge.
    task automatic cycle();
        logic          ireq, dreq, e_rd, e_wr, e_ir, e_dr;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_wdata;
        @(negedge clk);
        ireq = bus.icache_pmem_read;
        dreq = bus.dcache_pmem_read | bus.dcache_pmem_write;
        e_rd = 0; e_wr = 0; e_ir = 0; e_dr = 0; e_addr = '0; e_wdata = '0;
        if (!rst && m_owner == 1) begin
            e_rd   = ireq;
            e_addr = bus.icache_pmem_address - (bus.icache_pmem_address % 16);
            e_ir   = ireq && bus.pmem_resp;
        end else if (!rst && m_owner == 2) begin
            e_wr    = bus.dcache_pmem_write;
            e_rd    = bus.dcache_pmem_read && !bus.dcache_pmem_write;
            e_addr  = bus.dcache_pmem_address - (bus.dcache_pmem_address % 16);
            e_wdata = bus.dcache_pmem_wdata;
            e_dr    = dreq && bus.pmem_resp;
        end
        check("pmem_read", bus.pmem_read, e_rd);
        check("pmem_write", bus.pmem_write, e_wr);
        if (e_rd || e_wr) check("pmem_address", bus.pmem_address, e_addr);
        if (e_wr) check("pmem_wdata", bus.pmem_wdata, e_wdata);
        check("icache_resp", bus.icache_pmem_resp, e_ir);
        check("dcache_resp", bus.dcache_pmem_resp, e_dr);
        check("icache_rdata", bus.icache_pmem_rdata, bus.pmem_rdata);
        check("dcache_rdata", bus.dcache_pmem_rdata, bus.pmem_rdata);
        check("contention_count", contention_count, m_cont);
        check("transaction_count", transaction_count, m_trans);
        if (bus.icache_pmem_resp === 1'b1) i_pulses++;
        if (bus.dcache_pmem_resp === 1'b1) d_pulses++;
        @(posedge clk);
        if (rst) begin
            m_owner = 0; m_last = 2; m_cont = 0; m_trans = 0;
        end else if (m_owner == 0) begin
            if (ireq && dreq) begin
                m_owner = (m_last == 1) ? 2 : 1;
                if (m_cont < CMAX) m_cont++;
            end else if (ireq) begin
                m_owner = 1;
            end else if (dreq) begin
                m_owner = 2;
            end
            if (m_owner != 0) begin
                m_last = m_owner;
                grants.push_back(m_owner);
            end
        end else begin
            if (!((m_owner == 1) ? ireq : dreq)) begin
                m_owner = 0;
            end else if (bus.pmem_resp) begin
                m_owner = 0;
                if (m_trans < CMAX) m_trans++;
            end
        end
        #1;
    endtask

    initial begin
        bus.icache_pmem_read    = 0;
        bus.icache_pmem_address = '0;
        bus.dcache_pmem_read    = 0;
        bus.dcache_pmem_write   = 0;
        bus.dcache_pmem_address = '0;
        bus.dcache_pmem_wdata   = '0;
        bus.pmem_rdata          = {4{32'hA5A5_0F0F}};
        bus.pmem_resp           = 0;

        // Reset state
        rst = 1;
        cycle();
        cycle();
        check("reset_contention", contention_count, 0);
        check("reset_transaction", transaction_count, 0);
        rst = 0;

        // I-cache read of 0x1234, memory answers on the third serve cycle
        i_pulses = 0; d_pulses = 0;
        bus.icache_pmem_read = 1; bus.icache_pmem_address = 16'h1234;
        cycle();
        check("t1_read_strobe", bus.pmem_read, 1);
        check("t1_line_address", bus.pmem_address, 16'h1230);
        cycle();
        cycle();
        bus.pmem_resp = 1;
        cycle();
        bus.icache_pmem_read = 0; bus.pmem_resp = 0;
        cycle();
        check("t1_i_pulses", i_pulses, 1);
        check("t1_d_pulses", d_pulses, 0);
        check("t1_transactions", transaction_count, 1);

        // D-cache write-back to 0x4000
        i_pulses = 0; d_pulses = 0;
        bus.dcache_pmem_write = 1; bus.dcache_pmem_address = 16'h4000;
        bus.dcache_pmem_wdata = {32'hDEAD_0001, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_BEEF};
        cycle();
        check("t2_write_strobe", bus.pmem_write, 1);
        check("t2_read_strobe", bus.pmem_read, 0);
        check("t2_wdata", bus.pmem_wdata,
              {32'hDEAD_0001, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_BEEF});
        cycle();
        bus.pmem_resp = 1;
        cycle();
        bus.dcache_pmem_write = 0; bus.pmem_resp = 0;
        cycle();
        check("t2_d_pulses", d_pulses, 1);
        check("t2_i_pulses", i_pulses, 0);

        // Tie straight after reset: I first, then D after one idle cycle
        rst = 1;
        cycle();
        rst = 0;
        grants.delete();
        bus.icache_pmem_read = 1; bus.icache_pmem_address = 16'h1000;
        bus.dcache_pmem_read = 1; bus.dcache_pmem_address = 16'h2000;
        cycle();
        bus.pmem_resp = 1;
        cycle();
        bus.icache_pmem_read = 0; bus.pmem_resp = 0;
        cycle();
        bus.pmem_resp = 1;
        cycle();
        bus.dcache_pmem_read = 0; bus.pmem_resp = 0;
        cycle();
        check("t3_grant_count", grants.size(), 2);
        check("t3_first_grant", grants[0], 1);
        check("t3_second_grant", grants[1], 2);
        check("t3_contention", contention_count, 1);
        // I-only transaction makes last_grant=I, so the next tie goes to D
        bus.icache_pmem_read = 1;
        cycle();
        bus.pmem_resp = 1;
        cycle();
        bus.icache_pmem_read = 0; bus.pmem_resp = 0;
        cycle();
        bus.icache_pmem_read = 1; bus.dcache_pmem_read = 1;
        cycle();
        check("t3_tie_to_d", grants[grants.size()-1], 2);
        bus.pmem_resp = 1;
        cycle();
        bus.icache_pmem_read = 0; bus.dcache_pmem_read = 0; bus.pmem_resp = 0;
        cycle();

        // Continuous requests from both: strict alternation over 20 grants
        grants.delete();
        bus.icache_pmem_read = 1; bus.dcache_pmem_read = 1; bus.pmem_resp = 1;
        for (int k = 0; k < 40; k++) cycle();
        bus.icache_pmem_read = 0; bus.dcache_pmem_read = 0; bus.pmem_resp = 0;
        cycle();
        check("t4_grant_count", grants.size(), 20);
        for (int k = 1; k < grants.size(); k++)
            check("t4_alternation", grants[k] != grants[k-1], 1);

        // Reset while SERVE_D is stalled; late memory response is ignored
        bus.dcache_pmem_read = 1; bus.dcache_pmem_address = 16'h5557;
        cycle();
        cycle();
        rst = 1;
        cycle();
        check("t5_read_after_rst", bus.pmem_read, 0);
        check("t5_cont_after_rst", contention_count, 0);
        check("t5_trans_after_rst", transaction_count, 0);
        rst = 0;
        i_pulses = 0; d_pulses = 0;
        bus.dcache_pmem_read = 0; bus.pmem_resp = 1;
        cycle();
        cycle();
        bus.pmem_resp = 0;
        check("t5_no_late_resp", i_pulses + d_pulses, 0);

        // Saturate contention: tie in IDLE, abort, repeat 2^CW+5 times
        for (int k = 0; k < CMAX + 6; k++) begin
            bus.icache_pmem_read = 1; bus.dcache_pmem_read = 1;
            cycle();
            bus.icache_pmem_read = 0; bus.dcache_pmem_read = 0;
            cycle();
        end
        check("t6_contention_sat", contention_count, CMAX);

        // Random traffic against the model
        rst = 1;
        cycle();
        rst = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(3) == 0) begin
                bus.icache_pmem_read    = ($urandom_range(2) != 0);
                bus.icache_pmem_address = AW'($urandom);
            end
            if ($urandom_range(3) == 0) begin
                bus.dcache_pmem_read    = $urandom_range(1) == 1;
                bus.dcache_pmem_write   = $urandom_range(1) == 1;
                bus.dcache_pmem_address = AW'($urandom);
                bus.dcache_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
            end
            bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
            bus.pmem_resp  = ($urandom_range(2) == 0);
            rst            = ($urandom_range(499) == 0);
            cycle();
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Sits directly downstream of the I-cache and D-cache controllers and upstream of physical memory.
- Multiplexes two cache-line request ports onto one physical-memory port, one transaction at a time.
- Round-robin fairness applies when both caches request in the same cycle.
- Forwards the memory response only to the granted cache. Keeps saturating performance counters for contention.

Parameters:
ADDR_WIDTH, 16, byte address width (lc3b_word)
LINE_WIDTH, 128, cache line width in bits (16-byte line)
CNT_WIDTH, 16, width of performance counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
icache_pmem_read  in  1  I-cache line read request
icache_pmem_address  in  ADDR_WIDTH  I-cache line address
icache_pmem_rdata  out  LINE_WIDTH  line returned to I-cache
icache_pmem_resp  out  1  I-cache transaction complete
dcache_pmem_read  in  1  D-cache line read request
dcache_pmem_write  in  1  D-cache line write-back request
dcache_pmem_address  in  ADDR_WIDTH  D-cache line address
dcache_pmem_wdata  in  LINE_WIDTH  D-cache write-back line
dcache_pmem_rdata  out  LINE_WIDTH  line returned to D-cache
dcache_pmem_resp  out  1  D-cache transaction complete
pmem_read  out  1  memory read strobe
pmem_write  out  1  memory write strobe
pmem_address  out  ADDR_WIDTH  memory line address, low 4 bits forced to 0
pmem_wdata  out  LINE_WIDTH  memory write data
pmem_rdata  in  LINE_WIDTH  memory read data
pmem_resp  in  1  memory transaction complete
contention_count  out  CNT_WIDTH  idle cycles with both caches requesting, saturating
transaction_count  out  CNT_WIDTH  completed memory transactions, saturating

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset: state=IDLE, last_grant=DCACHE (so the first tie goes to the I-cache), both counters=0. All pmem_* strobes and both *_resp are 0 while rst is high.
- Reset mid-transaction: go to IDLE immediately with all strobes low. The in-flight memory response is discarded.
- States:
  - IDLE: no strobes asserted.
  - SERVE_I: drives pmem_read=1 and pmem_address=icache address.
  - SERVE_D: drives pmem_read or pmem_write from the D-cache strobes, address=dcache address, pmem_wdata=dcache_pmem_wdata.
- IDLE transitions, evaluated each cycle (ireq=icache_pmem_read, dreq=dcache_pmem_read|dcache_pmem_write):
  - Neither requesting: stay in IDLE.
  - Only ireq: go to SERVE_I.
  - Only dreq: go to SERVE_D.
  - Both: grant the port that is not last_grant, and increment contention_count (saturate at all-ones).
- last_grant updates on every IDLE->SERVE transition.
- SERVE_x with pmem_resp=1:
  - Assert x_pmem_resp=1 combinationally in the same cycle.
  - Go to IDLE next cycle.
  - Increment transaction_count (saturating).
- SERVE_x with the granted request dropped before pmem_resp (protocol abort): deassert strobes combinationally, return to IDLE, count nothing.
- Latency:
  - Request seen in IDLE at cycle t produces the memory strobe at t+1.
  - At least one IDLE cycle separates consecutive transactions.
  - A response never reaches the non-granted port.
- D-cache strobes: if dcache_pmem_read and dcache_pmem_write are both high, the write takes precedence.
- Read data: pmem_rdata is broadcast unregistered to both *_rdata. Only the resp strobe is gated.
- Write-back atomicity: a D-cache write-back followed by its allocate is not atomic. An I-cache request may be served between them; this is legal.
- Waiting requester: strobes must be held by the requester until its resp. The arbiter stores no address or data.

Decomposition:
- Shared package lc3b_types gains:
  - typedef lc3b_line (logic [127:0]);
  - enum lc3b_arb_grant {GRANT_I, GRANT_D};
  - constant LC3B_LINE_OFFSET_BITS=4.
- One sub-module: sat_counter (parameterised width, inc and clear inputs). Instantiated twice.

Test Plan:
- I-cache only reads 0x1234 and memory responds after 3 cycles: pmem_address=0x1230 at t+1, icache_pmem_resp pulses exactly once, dcache_pmem_resp stays 0, transaction_count=1.
- D-cache write-back to 0x4000 with wdata=0xDEAD..BEEF: pmem_write=1, pmem_wdata matches, pmem_read=0, dcache_pmem_resp on memory response.
- Both caches request in the same IDLE cycle after reset: I-cache is served first, then D-cache after one IDLE cycle. contention_count=1; on the next tie the D-cache wins if last_grant=I.
- Both caches issue back-to-back requests continuously for 20 transactions: grants alternate I/D strictly and neither port starves.
- rst asserted during SERVE_D while memory is stalled: the next cycle has IDLE, all strobes 0 and both counters 0. A later pmem_resp produces no *_resp.
- Force contention 2^16+5 times: contention_count holds at 0xFFFF.
